pc_3gpp_enc_sched: RTL

PC_3GPP_ENC_SCHED -- requirements
Module: pc_3gpp_enc_sched

---
 rtl/pc_3gpp_enc_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pc_3gpp_enc_sched.sv
// Round-robin scheduler that feeds one polar-encoder input stream from pCH_N
// serial channels. Each frame is length-checked against pDATA_N. Short frames
// are forwarded and flagged. Long frames are cut at pDATA_N with a forced eop,
// and their tail is discarded.
module pc_3gpp_enc_sched #(
    parameter int unsigned pCH_N   = 4,
    parameter int unsigned pDATA_N = 512,
    parameter int unsigned pTAG_W  = 4
) (
    input  logic                                iclk,
    input  logic                                ireset,
    input  logic                                iclkena,
    input  logic [pCH_N-1:0]                    ich_sop,
    input  logic [pCH_N-1:0]                    ich_val,
    input  logic [pCH_N-1:0]                    ich_eop,
    input  logic [pCH_N-1:0]                    ich_dat,
    input  logic [pCH_N*pTAG_W-1:0]             ich_tag,
    output logic [pCH_N-1:0]                    och_rdy,
    input  logic                                ienc_rdy,
    output logic                                oenc_sop,
    output logic                                oenc_val,
    output logic                                oenc_eop,
    output logic                                oenc_dat,
    output logic [$clog2(pCH_N)+pTAG_W-1:0]     oenc_tag,
    output logic                                ogrant_vld,
    output logic [$clog2(pCH_N)-1:0]            ogrant_ch,
    output logic                                oerr,
    output logic [$clog2(pCH_N)-1:0]            oerr_ch
);

    localparam int unsigned cCH_W  = $clog2(pCH_N);
    localparam int unsigned cCNT_W = $clog2(pDATA_N + 1);
    localparam logic [cCNT_W-1:0] cLAST = cCNT_W'(pDATA_N - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StPass, StFlush} state_e;

    state_e             state_q, state_d;
    logic [cCH_W-1:0]   grant_q, grant_d;
    logic [cCH_W-1:0]   ptr_q, ptr_d;
    logic [cCH_W-1:0]   err_ch_q, err_ch_d;
    logic [cCNT_W-1:0]  cnt_q, cnt_d;

    logic [pCH_N-1:0]   req, stray;
    logic               req_any, stray_any;
    logic [cCH_W-1:0]   arb_ch, stray_ch;
    logic               g_val, g_sop, g_eop, g_dat;
    logic [pTAG_W-1:0]  g_tag;
    logic               cnt_last, cnt_zero, pass_xfer;
    logic               err_pulse;
    logic [cCH_W-1:0]   err_src;

    // Granted-channel selection, round-robin arbiter and stray-beat detection.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        req       = ich_sop & ich_val;
        stray     = ich_val & ~ich_sop;
        req_any   = |req;
        stray_any = |stray;
        g_val     = ich_val[grant_q];
        g_sop     = ich_sop[grant_q];
        g_eop     = ich_eop[grant_q];
        g_dat     = ich_dat[grant_q];
        g_tag     = ich_tag[32'(grant_q)*pTAG_W +: pTAG_W];
        cnt_last  = (cnt_q == cLAST);
        cnt_zero  = (cnt_q == '0);
        pass_xfer = g_val & ienc_rdy;
        // Scan from farthest to nearest so the channel right after ptr wins.
        arb_ch = '0;
        for (int unsigned i = pCH_N; i >= 1; i--) begin
            idx = 32'(ptr_q) + i;
            if (idx >= pCH_N) idx = idx - pCH_N;
            if (req[idx]) arb_ch = cCH_W'(idx);
        end
        stray_ch = '0;
        for (int i = pCH_N - 1; i >= 0; i--) begin
            if (stray[i]) stray_ch = cCH_W'(i);
        end
    end

    // State, grant, pointer, counter and error-channel registers.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            ptr_q    <= cCH_W'(pCH_N - 1);
            cnt_q    <= '0;
            err_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_ch_q <= err_ch_d;
        end
    end

    // Next-state logic; nothing moves while the clock enable is low.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_ch_d = err_ch_q;
        if (iclkena) begin
            if (err_pulse) err_ch_d = err_src;
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        grant_d = arb_ch;
                        state_d = StGrant;
                    end
                end
                StGrant: begin
                    cnt_d   = '0;
                    state_d = StPass;
                end
                StPass: begin
                    if (pass_xfer) begin
                        cnt_d = cnt_q + 1'b1;
                        if (g_eop) begin
                            state_d = StIdle;
                            ptr_d   = grant_q;
                        end else if (cnt_last) begin
                            state_d = StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (g_val && g_eop) begin
                        state_d = StIdle;
                        ptr_d   = grant_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        och_rdy    = '0;
        oenc_sop   = 1'b0;
        oenc_val   = 1'b0;
        oenc_eop   = 1'b0;
        oenc_dat   = 1'b0;
        oenc_tag   = '0;
        err_pulse  = 1'b0;
        err_src    = err_ch_q;
        ogrant_vld = (state_q != StIdle);
        ogrant_ch  = grant_q;
        if (ireset && state_q != StIdle) oenc_tag = {grant_q, g_tag};
        if (iclkena && ireset) begin
            case (state_q)
                StIdle, StGrant: begin
                    // Beats without sop outside a frame are swallowed and flagged.
                    och_rdy = stray;
                    if (stray_any) begin
                        err_pulse = 1'b1;
                        err_src   = stray_ch;
                    end
                end
                StPass: begin
                    och_rdy[grant_q] = ienc_rdy;
                    oenc_val = g_val;
                    oenc_dat = g_dat;
                    oenc_eop = g_eop | cnt_last;
                    oenc_sop = g_sop & cnt_zero;
                    if (pass_xfer && ((g_eop && !cnt_last) || (!g_eop && cnt_last) ||
                                      (g_sop && !cnt_zero))) begin
                        err_pulse = 1'b1;
                        err_src   = grant_q;
                    end
                end
                StFlush: begin
                    och_rdy[grant_q] = 1'b1;
                end
                default: ;
            endcase
        end
        oerr    = err_pulse;
        oerr_ch = err_pulse ? err_src : err_ch_q;
    end

endmodule
